// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared encodings for the multi-cycle ALU sequencer
//
// Holds the funct3 op encodings, the sequencer state encoding and the
// number of divide iterations. Imported by xc_malu_fixup and xc_malu_ctrl.

package xc_malu_pkg;

    // funct3 order of the M-extension ops
    localparam logic [2:0] XC_MALU_OP_MUL    = 3'd0;
    localparam logic [2:0] XC_MALU_OP_MULH   = 3'd1;
    localparam logic [2:0] XC_MALU_OP_MULHSU = 3'd2;
    localparam logic [2:0] XC_MALU_OP_MULHU  = 3'd3;
    localparam logic [2:0] XC_MALU_OP_DIV    = 3'd4;
    localparam logic [2:0] XC_MALU_OP_DIVU   = 3'd5;
    localparam logic [2:0] XC_MALU_OP_REM    = 3'd6;
    localparam logic [2:0] XC_MALU_OP_REMU   = 3'd7;

    // Iterations the divide unit needs; ready is expected when count reaches it
    localparam int XC_MALU_DIV_STEPS = 32;

    typedef enum logic [1:0] {
        XC_MALU_ST_IDLE = 2'd0,
        XC_MALU_ST_BUSY = 2'd1,
        XC_MALU_ST_DONE = 2'd2
    } xc_malu_state_t;

    // DIV/DIVU/REM/REMU all have funct3[2] set
    function automatic logic xc_malu_op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/xc_malu_fixup.sv
// rtl/xc_malu_fixup.sv - combinational sign fixup and result select
//
// Ports:
//   i_op       3       operation (funct3 order)
//   i_rs1_sgn  1       sign bit of captured rs1
//   i_rs2_sgn  1       sign bit of captured rs2
//   i_rs2_zero 1       captured rs2 is zero
//   i_acc      2*XLEN  accumulator (multiply product)
//   i_arg_0    XLEN    remainder magnitude
//   i_arg_1    XLEN    quotient magnitude
//   o_result   XLEN    final architectural result

module xc_malu_fixup
    import xc_malu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        i_op,
    input  logic              i_rs1_sgn,
    input  logic              i_rs2_sgn,
    input  logic              i_rs2_zero,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_arg_0,
    input  logic [XLEN-1:0]   i_arg_1,
    output logic [XLEN-1:0]   o_result
);

    logic w_div_neg;
    logic w_rem_neg;

    // Divide by zero leaves the all-ones quotient un-negated; the remainder
    // follows the dividend sign, which also makes x/0 return x.
    assign w_div_neg = (i_op == XC_MALU_OP_DIV) && (i_rs1_sgn ^ i_rs2_sgn) && !i_rs2_zero;
    assign w_rem_neg = (i_op == XC_MALU_OP_REM) && i_rs1_sgn;

    always_comb begin
        o_result = '0;
        case (i_op)
            XC_MALU_OP_MUL:
                o_result = i_acc[XLEN-1:0];
            XC_MALU_OP_MULH, XC_MALU_OP_MULHSU, XC_MALU_OP_MULHU:
                o_result = i_acc[2*XLEN-1:XLEN];
            XC_MALU_OP_DIV, XC_MALU_OP_DIVU:
                o_result = w_div_neg ? (-i_arg_1) : i_arg_1;
            default:
                o_result = w_rem_neg ? (-i_arg_0) : i_arg_0;
        endcase
    end

endmodule

// File: rtl/xc_malu_ctrl.sv
// rtl/xc_malu_ctrl.sv - multi-cycle ALU sequencer (IDLE/BUSY/DONE)
//
// Accepts one MUL/DIV/REM request, owns count/acc/arg_0/arg_1, drives the
// selected iteration unit, commits its next state and holds the result until
// the consumer takes it.
//
// Optional feature macro: XC_MALU_DIVZERO_FAST_EN
//   defined   - DIV*/REM* by zero completes on the accepting edge
//   undefined - divide by zero iterates like any other divide
//
// Ports:
//   clock, resetn                      clock, async active-low reset
//   req_valid/req_ready/req_op/rs1/rs2 request handshake and operands
//   flush                              abort, drop any result
//   rsp_valid/rsp_ready/rsp_result     response handshake and result
//   u_rs1/u_rs2/u_count/u_acc/u_arg_*  shared state presented to the units
//   u_signed/u_lhs_sgn/u_rhs_sgn       operand signedness for the units
//   mul_valid/div_valid/u_flush        unit enables and forwarded flush
//   mul_n_*/mul_ready, div_n_*/div_ready  unit next-state and completion

module xc_malu_ctrl
    import xc_malu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_result,
    output logic [XLEN-1:0]   u_rs1,
    output logic [XLEN-1:0]   u_rs2,
    output logic [CNT_W-1:0]  u_count,
    output logic [2*XLEN-1:0] u_acc,
    output logic [XLEN-1:0]   u_arg_0,
    output logic [XLEN-1:0]   u_arg_1,
    output logic              u_signed,
    output logic              u_lhs_sgn,
    output logic              u_rhs_sgn,
    output logic              mul_valid,
    output logic              div_valid,
    output logic              u_flush,
    input  logic [2*XLEN-1:0] mul_n_acc,
    input  logic [XLEN-1:0]   mul_n_arg_0,
    input  logic [XLEN-1:0]   mul_n_arg_1,
    input  logic              mul_ready,
    input  logic [2*XLEN-1:0] div_n_acc,
    input  logic [XLEN-1:0]   div_n_arg_0,
    input  logic [XLEN-1:0]   div_n_arg_1,
    input  logic              div_ready
);

    xc_malu_state_t    r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [CNT_W-1:0]  r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_arg_0;
    logic [XLEN-1:0]   r_arg_1;
    logic              r_start;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_mul_valid;
    logic              r_div_valid;

    logic              w_sel_div;
    logic [2*XLEN-1:0] w_n_acc;
    logic [XLEN-1:0]   w_n_arg_0;
    logic [XLEN-1:0]   w_n_arg_1;
    logic              w_unit_ready;
    logic [XLEN-1:0]   w_result;
    logic              w_count_max;

    // Unit mux: the captured op picks which unit's next state is committed
    assign w_sel_div    = xc_malu_op_is_div(r_op);
    assign w_n_acc      = w_sel_div ? div_n_acc   : mul_n_acc;
    assign w_n_arg_0    = w_sel_div ? div_n_arg_0 : mul_n_arg_0;
    assign w_n_arg_1    = w_sel_div ? div_n_arg_1 : mul_n_arg_1;
    assign w_unit_ready = w_sel_div ? div_ready   : mul_ready;
    assign w_count_max  = (r_count == CNT_W'(XC_MALU_DIV_STEPS));

`ifdef XC_MALU_DIVZERO_FAST_EN
    logic            w_req_div_zero;
    logic [XLEN-1:0] w_fast_result;

    // Same values the iterative path produces: quotient all ones, remainder rs1
    assign w_req_div_zero = xc_malu_op_is_div(req_op) && (req_rs2 == '0);
    assign w_fast_result  = req_op[1] ? req_rs1 : '1;
`endif

    xc_malu_fixup #(
        .XLEN (XLEN)
    ) u_fixup (
        .i_op       (r_op),
        .i_rs1_sgn  (r_rs1[XLEN-1]),
        .i_rs2_sgn  (r_rs2[XLEN-1]),
        .i_rs2_zero (r_rs2 == '0),
        .i_acc      (r_acc),
        .i_arg_0    (r_arg_0),
        .i_arg_1    (r_arg_1),
        .o_result   (w_result)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= XC_MALU_ST_IDLE;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_arg_0     <= '0;
            r_arg_1     <= '0;
            r_start     <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= XC_MALU_ST_IDLE;
            r_start     <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
        end else begin
            case (r_state)
                XC_MALU_ST_IDLE: begin
                    // req_ready is low for the first cycle out of reset
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_rs1       <= req_rs1;
                        r_rs2       <= req_rs2;
                        r_count     <= '0;
                        r_req_ready <= 1'b0;
`ifdef XC_MALU_DIVZERO_FAST_EN
                        if (w_req_div_zero) begin
                            r_state     <= XC_MALU_ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_result    <= w_fast_result;
                        end else
`endif
                        begin
                            r_state     <= XC_MALU_ST_BUSY;
                            r_start     <= 1'b1;
                            r_mul_valid <= !xc_malu_op_is_div(req_op);
                            r_div_valid <= xc_malu_op_is_div(req_op);
                        end
                    end
                end
                XC_MALU_ST_BUSY: begin
                    r_start <= 1'b0;
                    if (w_unit_ready) begin
                        // Result comes from the state already committed; the
                        // unit's next state this cycle is discarded.
                        r_result    <= w_result;
                        r_rsp_valid <= 1'b1;
                        r_mul_valid <= 1'b0;
                        r_div_valid <= 1'b0;
                        r_state     <= XC_MALU_ST_DONE;
                    end else begin
                        r_acc   <= w_n_acc;
                        r_arg_0 <= w_n_arg_0;
                        r_arg_1 <= w_n_arg_1;
                        // Start cycle holds count at 0; saturate at the step limit
                        if (!r_start && !w_count_max) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                XC_MALU_ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= XC_MALU_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= XC_MALU_ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign u_rs1      = r_rs1;
    assign u_rs2      = r_rs2;
    assign u_count    = r_count;
    assign u_acc      = r_acc;
    assign u_arg_0    = r_arg_0;
    assign u_arg_1    = r_arg_1;
    assign u_signed   = (r_op == XC_MALU_OP_DIV) || (r_op == XC_MALU_OP_REM);
    assign u_lhs_sgn  = (r_op == XC_MALU_OP_MULH) || (r_op == XC_MALU_OP_MULHSU);
    assign u_rhs_sgn  = (r_op == XC_MALU_OP_MULH);
    assign mul_valid  = r_mul_valid;
    assign div_valid  = r_div_valid;
    assign u_flush    = flush;

endmodule

// File: tb/tb_xc_malu_ctrl.sv
// tb/tb_xc_malu_ctrl.sv - directed self-checking bench for xc_malu_ctrl

module tb_xc_malu_ctrl;

`ifdef XC_MALU_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] u_rs1, u_rs2;
    logic [5:0]  u_count;
    logic [63:0] u_acc;
    logic [31:0] u_arg_0, u_arg_1;
    logic        u_signed, u_lhs_sgn, u_rhs_sgn;
    logic        mul_valid, div_valid, u_flush;
    logic [63:0] mul_n_acc, div_n_acc;
    logic [31:0] mul_n_arg_0, mul_n_arg_1, div_n_arg_0, div_n_arg_1;
    logic        mul_ready, div_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    xc_malu_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .u_rs1(u_rs1), .u_rs2(u_rs2), .u_count(u_count), .u_acc(u_acc),
        .u_arg_0(u_arg_0), .u_arg_1(u_arg_1), .u_signed(u_signed),
        .u_lhs_sgn(u_lhs_sgn), .u_rhs_sgn(u_rhs_sgn),
        .mul_valid(mul_valid), .div_valid(div_valid), .u_flush(u_flush),
        .mul_n_acc(mul_n_acc), .mul_n_arg_0(mul_n_arg_0), .mul_n_arg_1(mul_n_arg_1),
        .mul_ready(mul_ready),
        .div_n_acc(div_n_acc), .div_n_arg_0(div_n_arg_0), .div_n_arg_1(div_n_arg_1),
        .div_ready(div_ready)
    );

    // Iteration unit models: single-shot multiplier, restoring divider on magnitudes
    logic mul_prev, div_prev, mul_first, div_first;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mul_prev <= 1'b0;
            div_prev <= 1'b0;
        end else begin
            mul_prev <= mul_valid;
            div_prev <= div_valid;
        end
    end
    assign mul_first = mul_valid && !mul_prev;
    assign div_first = div_valid && !div_prev;
    assign mul_ready = mul_valid && !mul_first;
    assign div_ready = div_valid && !div_first && (u_count == 6'd32);

    logic [63:0] m_lhs, m_rhs;
    logic [31:0] mag_a, mag_b;
    logic [32:0] t_rem, t_sub;
    always_comb begin
        m_lhs = u_lhs_sgn ? {{32{u_rs1[31]}}, u_rs1} : {32'd0, u_rs1};
        m_rhs = u_rhs_sgn ? {{32{u_rs2[31]}}, u_rs2} : {32'd0, u_rs2};
        mul_n_acc   = mul_first ? (m_lhs * m_rhs) : u_acc;
        mul_n_arg_0 = u_arg_0;
        mul_n_arg_1 = u_arg_1;

        mag_a = (u_signed && u_rs1[31]) ? (32'd0 - u_rs1) : u_rs1;
        mag_b = (u_signed && u_rs2[31]) ? (32'd0 - u_rs2) : u_rs2;
        t_rem = {u_arg_0, u_arg_1[31]};
        t_sub = t_rem - {1'b0, u_acc[31:0]};
        div_n_acc   = u_acc;
        div_n_arg_0 = u_arg_0;
        div_n_arg_1 = u_arg_1;
        if (div_first) begin
            div_n_acc   = {32'd0, mag_b};
            div_n_arg_0 = 32'd0;
            div_n_arg_1 = mag_a;
        end else if (t_rem >= {1'b0, u_acc[31:0]}) begin
            div_n_arg_0 = t_sub[31:0];
            div_n_arg_1 = {u_arg_1[30:0], 1'b1};
        end else begin
            div_n_arg_0 = t_rem[31:0];
            div_n_arg_1 = {u_arg_1[30:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for req_ready, presents a request and returns #1 after the accepting edge
    task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_req_ready"}, req_ready, 1);
        req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until rsp_valid is seen
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        @(negedge clock) rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        start_op(tag, op, a, b);
        wait_rsp(lat);
        check({tag, "_result"}, rsp_result, exp);
        take_rsp();
    endtask

    int          lat;
    int          seen;
    bit          stable;

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        flush = 1'b0; rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_valid", div_valid, 0);
        check("rst_count", u_count, 0);
        check("rst_acc", u_acc, 0);
        @(negedge clock) resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_req_ready", req_ready, 1);

        // DIVU 100,7: start cycle, latency, count at completion
        start_op("divu", OP_DIVU, 32'd100, 32'd7);
        check("divu_k0_div_valid", div_valid, 1);
        check("divu_k0_mul_valid", mul_valid, 0);
        check("divu_k0_count", u_count, 0);
        wait_rsp(lat);
        check("divu_latency", lat, 34);
        check("divu_result", rsp_result, 32'd14);
        check("divu_done_count", u_count, 32);
        check("divu_done_div_valid", div_valid, 0);
        check("divu_done_req_ready", req_ready, 0);
        take_rsp();
        check("divu_after_rsp_valid", rsp_valid, 0);
        check("divu_after_req_ready", req_ready, 1);

        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2);

        start_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_signed", u_signed, 1);
        wait_rsp(lat);
        check("div_neg_result", rsp_result, 32'hFFFF_FFFD);
        take_rsp();
        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Divide by zero: full iteration, or immediate with the fast path
        start_op("divu_z", OP_DIVU, 32'h1234, 32'd0);
        check("divu_z_div_valid", div_valid, FAST ? 0 : 1);
        wait_rsp(lat);
        check("divu_z_latency", lat, FAST ? 0 : 34);
        check("divu_z_result", rsp_result, 32'hFFFF_FFFF);
        take_rsp();
        run_op("rem_z", OP_REM, 32'h1234, 32'd0, 32'h1234);

        // Multiply path and result select
        start_op("mul", OP_MUL, 32'd7, 32'd6);
        check("mul_mul_valid", mul_valid, 1);
        check("mul_div_valid", div_valid, 0);
        wait_rsp(lat);
        check("mul_result", rsp_result, 32'd42);
        take_rsp();
        start_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'd2);
        check("mulh_sgn", {u_lhs_sgn, u_rhs_sgn}, 2'b11);
        wait_rsp(lat);
        check("mulh_result", rsp_result, 32'hFFFF_FFFF);
        take_rsp();
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1);

        // Flush at k=10 drops the operation
        start_op("flush", OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_req_ready", req_ready, 1);
        check("flush_div_valid", div_valid, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("flush_no_rsp", seen, 0);
        run_op("post_flush", OP_DIVU, 32'd9, 32'd3, 32'd3);

        // Back-pressure in DONE: result held, new request not accepted
        start_op("hold", OP_DIVU, 32'd50, 32'd5);
        wait_rsp(lat);
        @(negedge clock);
        req_op = OP_DIVU; req_rs1 = 32'd1; req_rs2 = 32'd1; req_valid = 1'b1;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (rsp_result !== 32'd10 || req_ready !== 1'b0 || rsp_valid !== 1'b1) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_not_accepted", u_rs1, 32'd50);
        take_rsp();
        check("hold_req_ready", req_ready, 1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        check("hold_next_accepted", u_rs1, 32'd1);
        wait_rsp(lat);
        check("hold_next_result", rsp_result, 32'd1);
        take_rsp();

        // Asynchronous reset at k=5
        start_op("arst", OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("arst_div_valid", div_valid, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_rsp", {rsp_valid, rsp_result}, 0);
        check("arst_state", {u_count, u_acc, u_arg_0, u_arg_1, u_rs1}, 0);
        @(negedge clock) resetn = 1'b1;
        run_op("post_rst", OP_DIVU, 32'd9, 32'd3, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
